// File: rtl/luz_pwm_rampa.sv
// Lamp driver after the alarm block: ramps a working duty level toward the commanded
// brightness in timed steps and drives a glitch-free PWM that reloads only at period ends.
module luz_pwm_rampa #(
    parameter int PWM_BITS = 16,
    parameter int RAMP_DIV = 50000,
    parameter int STEP     = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sonando,
    input  logic [1:0]          accion,
    input  logic [PWM_BITS-1:0] dutty,
    output logic                pwm,
    output logic [PWM_BITS-1:0] level,
    output logic [1:0]          estado,
    output logic                busy,
    output logic                period_start
);

    localparam int LW = PWM_BITS + 1;
    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
    localparam logic [LW-1:0] STEP_W     = LW'(STEP);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_UP   = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b10;
    localparam logic [1:0] S_DOWN = 2'b11;

    localparam logic [1:0] C_OFF  = 2'b00;
    localparam logic [1:0] C_UP   = 2'b01;
    localparam logic [1:0] C_HOLD = 2'b10;
    localparam logic [1:0] C_DOWN = 2'b11;

    // One extra bit so a step past the top of the range is seen rather than wrapped.
    function automatic logic [LW-1:0] f_step_up(input logic [PWM_BITS-1:0] lvl);
        return {1'b0, lvl} + STEP_W;
    endfunction

    function automatic logic [PWM_BITS-1:0] f_step_down(input logic [PWM_BITS-1:0] lvl);
        logic [LW-1:0] diff;
        diff = {1'b0, lvl} - STEP_W;
        return diff[PWM_BITS-1:0];
    endfunction

    logic [1:0]          r_state;
    logic [PWM_BITS-1:0] r_level;
    logic [PW-1:0]       r_presc;
    logic [PWM_BITS-1:0] r_cnt;
    logic [PWM_BITS-1:0] r_shadow;
    logic                r_pwm;
    logic                r_period_start;

    logic [1:0]          w_cmd;
    logic                w_in_ramp;
    logic                w_tick;
    logic [LW-1:0]       w_up_sum;
    logic                w_down_empty;
    logic [1:0]          w_state_nx;
    logic [PWM_BITS-1:0] w_level_nx;
    logic                w_ramp_entry;
    logic                w_nx_in_ramp;
    logic                w_cnt_last;

    assign w_cmd        = sonando ? accion : C_DOWN;
    assign w_in_ramp    = (r_state == S_UP) || (r_state == S_DOWN);
    assign w_tick       = w_in_ramp && (r_presc == PRESC_LAST);
    assign w_up_sum     = f_step_up(r_level);
    assign w_down_empty = ({1'b0, r_level} <= STEP_W);
    assign w_nx_in_ramp = (w_state_nx == S_UP) || (w_state_nx == S_DOWN);
    assign w_cnt_last   = (r_cnt == {PWM_BITS{1'b1}});

    // Commands are resolved first (off > down > hold > up); a tick only steps when no command moved the FSM.
    always_comb begin
        w_state_nx   = r_state;
        w_level_nx   = r_level;
        w_ramp_entry = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_level_nx = '0;
                if (w_cmd == C_HOLD) begin
                    w_state_nx = S_HOLD;
                    w_level_nx = dutty;
                end else if (w_cmd == C_UP && dutty != '0) begin
                    w_state_nx   = S_UP;
                    w_ramp_entry = 1'b1;
                end
            end
            S_UP: begin
                if (w_cmd == C_OFF) begin
                    w_state_nx = S_IDLE;
                    w_level_nx = '0;
                end else if (w_cmd == C_DOWN) begin
                    w_state_nx   = S_DOWN;
                    w_ramp_entry = 1'b1;
                end else if (w_cmd == C_HOLD || r_level >= dutty) begin
                    w_state_nx = S_HOLD;
                    w_level_nx = dutty;
                end else if (w_tick) begin
                    if (w_up_sum >= {1'b0, dutty}) begin
                        w_state_nx = S_HOLD;
                        w_level_nx = dutty;
                    end else begin
                        w_level_nx = w_up_sum[PWM_BITS-1:0];
                    end
                end
            end
            S_HOLD: begin
                if (w_cmd == C_OFF) begin
                    w_state_nx = S_IDLE;
                    w_level_nx = '0;
                end else if (w_cmd == C_DOWN) begin
                    w_state_nx   = S_DOWN;
                    w_ramp_entry = 1'b1;
                end else begin
                    w_level_nx = dutty;
                end
            end
            S_DOWN: begin
                if (w_cmd == C_OFF) begin
                    w_state_nx = S_IDLE;
                    w_level_nx = '0;
                end else if (w_cmd == C_HOLD) begin
                    w_state_nx = S_HOLD;
                    w_level_nx = dutty;
                end else if (w_cmd == C_UP && dutty > r_level) begin
                    w_state_nx   = S_UP;
                    w_ramp_entry = 1'b1;
                end else if (w_tick) begin
                    if (w_down_empty) begin
                        w_state_nx = S_IDLE;
                        w_level_nx = '0;
                    end else begin
                        w_level_nx = f_step_down(r_level);
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_level_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_level <= '0;
            r_presc <= '0;
        end else begin
            r_state <= w_state_nx;
            r_level <= w_level_nx;
            if (w_ramp_entry || !w_nx_in_ramp || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // PWM stage: shadow reloads on the last count so a new level starts cleanly with the next period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_shadow       <= '0;
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_cnt          <= r_cnt + 1'b1;
            r_pwm          <= (r_cnt < r_shadow);
            r_period_start <= w_cnt_last;
            if (w_cnt_last) begin
                r_shadow <= r_level;
            end
        end
    end

    assign pwm          = r_pwm;
    assign level        = r_level;
    assign estado       = r_state;
    assign busy         = w_in_ramp;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_luz_pwm_rampa.sv
// Scenario bench for luz_pwm_rampa with a 4-bit PWM, 4-clock ramp steps and a step of 3.
module tb_luz_pwm_rampa;

    logic       clk;
    logic       rst;
    logic       sonando;
    logic [1:0] accion;
    logic [3:0] dutty;
    logic       pwm;
    logic [3:0] level;
    logic [1:0] estado;
    logic       busy;
    logic       period_start;

    int checks;
    int failures;

    typedef struct {
        int lvl;
        int k;
    } exp_t;

    exp_t sb_q[$];
    int   cnt_q[$];

    luz_pwm_rampa #(.PWM_BITS(4), .RAMP_DIV(4), .STEP(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .sonando      (sonando),
        .accion       (accion),
        .dutty        (dutty),
        .pwm          (pwm),
        .level        (level),
        .estado       (estado),
        .busy         (busy),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1; sonando = 1'b1; accion = 2'b01; dutty = 4'd10;
        repeat (3) @(negedge clk);
        checks++; if (pwm !== 1'b0) begin failures++; $display("FAIL reset_pwm got=%b exp=0", pwm); end
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (estado !== 2'b00) begin failures++; $display("FAIL reset_estado got=%b exp=00", estado); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (period_start !== 1'b0) begin failures++; $display("FAIL reset_period_start got=%b exp=0", period_start); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (estado !== 2'b01) begin failures++; $display("FAIL release_estado got=%b exp=01", estado); end
    endtask

    task automatic test_sunrise();
        int   lv[4] = '{3, 6, 9, 10};
        int   at[4] = '{4, 8, 12, 16};
        exp_t e;
        logic [3:0] prev;
        for (int i = 0; i < 4; i++) begin
            e.lvl = lv[i]; e.k = at[i];
            sb_q.push_back(e);
        end
        prev = level;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (level !== prev) begin
                checks++;
                e = sb_q.pop_front();
                if (level !== 4'(e.lvl) || k != e.k) begin
                    failures++;
                    $display("FAIL sunrise_step got level=%0d at cycle %0d exp level=%0d at cycle %0d", level, k, e.lvl, e.k);
                end
                prev = level;
            end
            if (sb_q.size() == 0) break;
        end
        if (sb_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL sunrise_timeout got %0d steps pending exp 0", sb_q.size());
            sb_q.delete();
        end
        checks++; if (estado !== 2'b10) begin failures++; $display("FAIL sunrise_hold got=%b exp=10", estado); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sunrise_busy got=%b exp=0", busy); end
    endtask

    task automatic test_pwm_shape();
        int n;
        int hi;
        int ps;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (period_start === 1'b1) begin
                n++;
                if (n == 2) break;
            end
        end
        checks++; if (n != 2) begin failures++; $display("FAIL pwm_sync got=%0d period starts exp=2", n); end
        cnt_q.push_back(10);
        hi = int'(pwm);
        repeat (15) begin @(negedge clk); hi += int'(pwm); end
        checks++; if (hi != cnt_q.pop_front()) begin failures++; $display("FAIL pwm_duty10 got=%0d high cycles exp=10", hi); end
        @(negedge clk);
        checks++; if (period_start !== 1'b1) begin failures++; $display("FAIL pwm_period got=%b exp=1", period_start); end
        repeat (5) @(negedge clk);
        dutty = 4'd5;
        cnt_q.push_back(5);
        @(negedge clk);
        checks++; if (level !== 4'd5) begin failures++; $display("FAIL hold_track got=%0d exp=5", level); end
        hi = int'(pwm);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (period_start === 1'b1) begin n = 1; break; end
            hi += int'(pwm);
        end
        checks++; if (n != 1) begin failures++; $display("FAIL pwm_boundary_timeout got=%0d exp=1", n); end
        checks++; if (hi != cnt_q.pop_front()) begin failures++; $display("FAIL pwm_old_shadow got=%0d high cycles exp=5", hi); end
        cnt_q.push_back(5);
        hi = int'(pwm);
        ps = int'(period_start);
        repeat (15) begin @(negedge clk); hi += int'(pwm); ps += int'(period_start); end
        checks++; if (hi != cnt_q.pop_front()) begin failures++; $display("FAIL pwm_duty5 got=%0d high cycles exp=5", hi); end
        checks++; if (ps != 1) begin failures++; $display("FAIL period_pulse got=%0d pulses exp=1", ps); end
        dutty = 4'd10;
        @(negedge clk);
        checks++; if (level !== 4'd10) begin failures++; $display("FAIL hold_retrack got=%0d exp=10", level); end
    endtask

    task automatic test_fade_out();
        int   lv[4] = '{7, 4, 1, 0};
        int   at[4] = '{4, 8, 12, 16};
        exp_t e;
        logic [3:0] prev;
        int n;
        int hi;
        sonando = 1'b0;
        @(negedge clk);
        checks++; if (estado !== 2'b11 || busy !== 1'b1) begin failures++; $display("FAIL fade_entry got estado=%b busy=%b exp estado=11 busy=1", estado, busy); end
        for (int i = 0; i < 4; i++) begin
            e.lvl = lv[i]; e.k = at[i];
            sb_q.push_back(e);
        end
        prev = level;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (level !== prev) begin
                checks++;
                e = sb_q.pop_front();
                if (level !== 4'(e.lvl) || k != e.k) begin
                    failures++;
                    $display("FAIL fade_step got level=%0d at cycle %0d exp level=%0d at cycle %0d", level, k, e.lvl, e.k);
                end
                prev = level;
            end
            if (sb_q.size() == 0) break;
        end
        if (sb_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL fade_timeout got %0d steps pending exp 0", sb_q.size());
            sb_q.delete();
        end
        checks++; if (estado !== 2'b00) begin failures++; $display("FAIL fade_idle got=%b exp=00", estado); end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (period_start === 1'b1) begin
                n++;
                if (n == 2) break;
            end
        end
        cnt_q.push_back(0);
        hi = int'(pwm);
        repeat (15) begin @(negedge clk); hi += int'(pwm); end
        checks++; if (hi != cnt_q.pop_front() || n != 2) begin failures++; $display("FAIL fade_pwm_off got=%0d high cycles (%0d starts) exp=0", hi, n); end
    endtask

    task automatic test_priority();
        sonando = 1'b1; accion = 2'b01; dutty = 4'd10;
        @(negedge clk);
        checks++; if (estado !== 2'b01) begin failures++; $display("FAIL prio_entry got=%b exp=01", estado); end
        repeat (4) @(negedge clk);
        checks++; if (level !== 4'd3) begin failures++; $display("FAIL prio_first_step got=%0d exp=3", level); end
        repeat (3) @(negedge clk);
        accion = 2'b00;
        @(negedge clk);
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL prio_level got=%0d exp=0", level); end
        checks++; if (estado !== 2'b00) begin failures++; $display("FAIL prio_estado got=%b exp=00", estado); end
    endtask

    task automatic test_retarget();
        accion = 2'b01; dutty = 4'd10;
        @(negedge clk);
        repeat (8) @(negedge clk);
        checks++; if (level !== 4'd6) begin failures++; $display("FAIL retarget_pre got=%0d exp=6", level); end
        @(negedge clk);
        dutty = 4'd4;
        @(negedge clk);
        checks++; if (estado !== 2'b10 || level !== 4'd4) begin failures++; $display("FAIL retarget got estado=%b level=%0d exp estado=10 level=4", estado, level); end
        accion = 2'b00;
        @(negedge clk);
        checks++; if (estado !== 2'b00) begin failures++; $display("FAIL retarget_off got=%b exp=00", estado); end
    endtask

    task automatic test_midramp_reset();
        sonando = 1'b1; accion = 2'b10; dutty = 4'd10;
        @(negedge clk);
        checks++; if (estado !== 2'b10 || level !== 4'd10) begin failures++; $display("FAIL mr_hold got estado=%b level=%0d exp estado=10 level=10", estado, level); end
        sonando = 1'b0;
        @(negedge clk);
        repeat (4) @(negedge clk);
        checks++; if (estado !== 2'b11 || level !== 4'd7) begin failures++; $display("FAIL mr_down got estado=%b level=%0d exp estado=11 level=7", estado, level); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL mr_level got=%0d exp=0", level); end
        checks++; if (estado !== 2'b00) begin failures++; $display("FAIL mr_estado got=%b exp=00", estado); end
        checks++; if (busy !== 1'b0 || pwm !== 1'b0 || period_start !== 1'b0) begin failures++; $display("FAIL mr_outputs got busy=%b pwm=%b ps=%b exp all 0", busy, pwm, period_start); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (estado !== 2'b00) begin failures++; $display("FAIL mr_stay_idle got=%b exp=00 at cycle %0d", estado, i); end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_sunrise();
        test_pwm_shape();
        test_fade_out();
        test_priority();
        test_retarget();
        test_midramp_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/luz_pwm_rampa.md
Name: luz_pwm_rampa

Overview:
- Downstream stage of the alarm block. Consumes its `accion`, `dutty` and `Sonando` outputs and drives the lamp through a PWM output.
- Does not jump straight to the commanded brightness. Ramps the working duty level up (sunrise) or down (fade-out) in timed steps.
- Updates the PWM compare value only at period boundaries, so the output never glitches.
- Exports the current level and state for the display and debug logic.

Parameters:
- PWM_BITS, 16: width of the PWM counter, `dutty` and `level`.
- RAMP_DIV, 50000: clocks per ramp step (1 ms at 50 MHz).
- STEP, 64: level increment/decrement per ramp step. Must satisfy 1 ≤ STEP < 2^PWM_BITS.

Ports:
- clk, input, 1: system clock (50 MHz).
- rst, input, 1: synchronous, active-high reset.
- sonando, input, 1: alarm ringing flag; when low, accion is overridden.
- accion, input, 2: command. 00 = off, 01 = ramp up, 10 = hold at target, 11 = ramp down.
- dutty, input, PWM_BITS: target brightness.
- pwm, output, 1: registered PWM drive to the lamp.
- level, output, PWM_BITS: current working duty level.
- estado, output, 2: FSM state. 00 = IDLE, 01 = RAMP_UP, 10 = HOLD, 11 = RAMP_DOWN.
- busy, output, 1: high in RAMP_UP or RAMP_DOWN.
- period_start, output, 1: one-cycle pulse in the cycle where the PWM counter equals 0.

Behaviour:
- Reset (rst=1 at a clk edge) clears everything: pwm=0, level=0, estado=IDLE, busy=0, period_start=0, PWM counter=0, shadow duty=0, prescaler=0. Reset mid-ramp aborts the ramp immediately.
- PWM counter:
  - Free-running, increments every clk and wraps from 2^PWM_BITS-1 to 0.
  - Shadow duty loads `level` in the cycle the counter equals 2^PWM_BITS-1.
  - pwm <= (counter < shadow) on each clk, so it is registered with one cycle of latency.
  - shadow=0 gives a constant low output; shadow=2^PWM_BITS-1 gives high for all but one count per period.
- Effective command:
  - sonando=1: cmd = accion.
  - sonando=0: cmd = 11 (ramp down).
- Prescaler and tick:
  - Cleared to 0 on every entry into RAMP_UP or RAMP_DOWN, and held at 0 outside those states.
  - Otherwise counts 0..RAMP_DIV-1 and wraps.
  - tick = 1 when the prescaler equals RAMP_DIV-1, so the first step lands RAMP_DIV cycles after entry.
- Level arithmetic uses PWM_BITS+1 bits internally; level never wraps.
- IDLE (level held at 0):
  - cmd=01 and dutty>0 → RAMP_UP.
  - cmd=10 → HOLD, with level=dutty on the transition.
  - cmd=00 or 11 → stay.
- RAMP_UP:
  - cmd=00 → IDLE, level=0 next cycle.
  - cmd=11 → RAMP_DOWN from the current level.
  - cmd=10 → HOLD, level=dutty.
  - If level ≥ dutty (target lowered below level) → HOLD, level=dutty next cycle, without waiting for a tick.
  - On tick: if level+STEP ≥ dutty, then level=dutty and → HOLD; else level += STEP.
- HOLD:
  - level = dutty every cycle (tracks target changes with one cycle of latency).
  - cmd=00 → IDLE, level=0.
  - cmd=11 → RAMP_DOWN.
  - cmd=01 → stay.
- RAMP_DOWN:
  - cmd=00 → IDLE, level=0.
  - cmd=01 and dutty>level → RAMP_UP, continuing from the current level.
  - cmd=10 → HOLD, level=dutty.
  - On tick: if level ≤ STEP, then level=0 and → IDLE; else level -= STEP.
- Command priority within a cycle is 00 > 11 > 10 > 01, evaluated before the tick step. A command change and a tick in the same cycle means the command wins and the step is discarded.
- The level changes seen on `pwm` take effect only at the next period boundary (shadow load).

Test Plan:
(Bench parameters: PWM_BITS=4, RAMP_DIV=4, STEP=3.)
- Reset: hold rst 3 cycles with sonando=1, accion=01 → pwm=0, level=0, estado=00, busy=0. Release → estado=01 next cycle.
- Sunrise: sonando=1, accion=01, dutty=10 → level 0→3→6→9→10 at 4-cycle intervals; estado=10 after level reaches 10; busy falls with it.
- PWM shape: in HOLD with dutty=10 → pwm high for exactly 10 of every 16 cycles. A change to dutty=5 mid-period takes effect only after the next period_start.
- Fade-out: from HOLD at level=10, drop sonando to 0 → level 10→7→4→1→0 at 4-cycle intervals, then estado=00 and pwm constant 0.
- Priority/override: during RAMP_UP, assert accion=00 in the same cycle as a tick → level=0 and estado=00 next cycle, with no step applied.
- Mid-ramp reset: assert rst during RAMP_DOWN at level=7 → all outputs return to reset values next cycle. After release with sonando=0 → estado stays 00.
